rpn_key_frontend: RTL and testbench

Input conditioner that sits between the board pushbuttons/switches and rpncalc. It synchronizes and debounces the four active-low KEY inputs and detects a single clean press. At that press it captures mode and val and presents one command ({mode, key index}, val) to the calculator over a valid/ready handshake. It is the producer side of the mode/key/val interface that rpncalc consumes.

---
 rtl/rpn_pkg.sv | 36 +++
 rtl/rpn_debounce.sv | 63 ++++++
 rtl/rpn_key_frontend.sv | 148 ++++++++++++++
 tb/tb_rpn_key_frontend.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types and helpers for the rpncalc key front end.
// The RPNKEY_AUTOREPEAT_EN macro is consumed by rpn_key_frontend.
package rpn_pkg;

    typedef logic [3:0] rpn_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        HELD,
        BLOCK
    } fe_state_t;

    localparam logic [3:0] KEY_NONE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } key_idx_t;

    // Index of the single low key; valid is 0 for none or several low keys.
    function automatic key_idx_t onehot_low_idx(input logic [3:0] keys);
        key_idx_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (keys)
            4'b1110: r.idx = 2'd0;
            4'b1101: r.idx = 2'd1;
            4'b1011: r.idx = 2'd2;
            4'b0111: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rpn_debounce.sv
// Two-flop synchronizers for key/mode/val plus a single shared-counter
// debounce filter on the synchronized active-low key vector.
module rpn_debounce
    import rpn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned VAL_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_raw,
    input  logic [1:0]       mode_raw,
    input  logic [VAL_W-1:0] val_raw,
    output logic [3:0]       key_db,
    output logic [1:0]       mode_s,
    output logic [VAL_W-1:0] val_s
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       key_m;
    logic [3:0]       key_s;
    logic [1:0]       mode_m;
    logic [VAL_W-1:0] val_m;
    logic [CW-1:0]    cnt;

    // Bring the asynchronous board inputs into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_m  <= KEY_NONE;
            key_s  <= KEY_NONE;
            mode_m <= '0;
            mode_s <= '0;
            val_m  <= '0;
            val_s  <= '0;
        end else begin
            key_m  <= key_raw;
            key_s  <= key_m;
            mode_m <= mode_raw;
            mode_s <= mode_m;
            val_m  <= val_raw;
            val_s  <= val_m;
        end
    end

    // Adopt a new key vector only after it has differed from the
    // debounced one for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_db <= KEY_NONE;
            cnt    <= '0;
        end else if (key_s == key_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            key_db <= key_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rpn_key_frontend.sv
// Key front end for rpncalc: debounced single-press detection, command
// capture and valid/ready presentation of ({mode, key index}, val).
// Optional feature macro: RPNKEY_AUTOREPEAT_EN (auto-repeat while held).
module rpn_key_frontend
    import rpn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned VAL_W           = 16
`ifdef RPNKEY_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_raw,
    input  logic [1:0]       mode_raw,
    input  logic [VAL_W-1:0] val_raw,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [3:0]       cmd_op,
    output logic [VAL_W-1:0] cmd_val,
    output logic             multi_err,
    output logic [7:0]       press_cnt
);

    logic [3:0]       key_db;
    logic [3:0]       key_prev;
    logic [1:0]       mode_s;
    logic [VAL_W-1:0] val_s;
    fe_state_t        state;
    fe_state_t        state_next;
    key_idx_t         sel;
    logic             press;
    logic             capture;
    logic             err_next;
    logic             accept;

    rpn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .VAL_W          (VAL_W)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_raw),
        .mode_raw(mode_raw),
        .val_raw (val_raw),
        .key_db  (key_db),
        .mode_s  (mode_s),
        .val_s   (val_s)
    );

    assign sel       = onehot_low_idx(key_db);
    assign press     = (key_prev == KEY_NONE) && (key_db != KEY_NONE);
    assign cmd_valid = (state == EMIT);

`ifdef RPNKEY_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] HOLD_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] hold_cnt;
    logic [3:0]    held_key;
    logic          repeat_hit;

    assign repeat_hit = (key_db == held_key) && sel.valid && (hold_cnt == HOLD_LAST);

    // Hold timer: zeroed at every capture so repeats are REPEAT_CYCLES apart;
    // restarts if the held vector changes and saturates while EMIT stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            held_key <= KEY_NONE;
        end else if (capture) begin
            hold_cnt <= '0;
            held_key <= key_db;
        end else if ((state == EMIT || state == HELD) && key_db == held_key && sel.valid) begin
            if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + RW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end
`endif

    // Next-state and strobe decode.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    if (sel.valid) begin
                        capture    = 1'b1;
                        state_next = EMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BLOCK;
                    end
                end
            end
            EMIT: begin
                if (cmd_ready) begin
                    accept     = 1'b1;
                    state_next = (key_db == KEY_NONE) ? IDLE : HELD;
                end
            end
            HELD: begin
                if (key_db == KEY_NONE) state_next = IDLE;
`ifdef RPNKEY_AUTOREPEAT_EN
                else if (repeat_hit) begin
                    capture    = 1'b1;
                    state_next = EMIT;
                end
`endif
            end
            BLOCK: begin
                if (key_db == KEY_NONE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Command capture, error pulse and accepted-command counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev  <= KEY_NONE;
            cmd_op    <= '0;
            cmd_val   <= '0;
            multi_err <= 1'b0;
            press_cnt <= '0;
        end else begin
            key_prev  <= key_db;
            multi_err <= err_next;
            if (capture) begin
                cmd_op  <= rpn_op_t'({mode_s, sel.idx});
                cmd_val <= val_s;
            end
            if (accept) press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rpn_key_frontend.sv
// Self-checking bench for rpn_key_frontend with DEBOUNCE_CYCLES=4.
module tb_rpn_key_frontend;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_raw = 4'hF;
    logic [1:0]  mode_raw = 2'b00;
    logic [15:0] val_raw = 16'h0000;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_val;
    logic        multi_err;
    logic [7:0]  press_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_merr = 0;

    rpn_key_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .VAL_W          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw),
        .mode_raw (mode_raw),
        .val_raw  (val_raw),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_val  (cmd_val),
        .multi_err(multi_err),
        .press_cnt(press_cnt)
    );

`ifdef RPNKEY_AUTOREPEAT_EN
    logic        rp_valid;
    logic [3:0]  rp_op;
    logic [15:0] rp_val;
    logic        rp_err;
    logic [7:0]  rp_cnt;

    rpn_key_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .VAL_W          (16),
        .REPEAT_CYCLES  (32)
    ) u_rep (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw),
        .mode_raw (mode_raw),
        .val_raw  (val_raw),
        .cmd_valid(rp_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (rp_op),
        .cmd_val  (rp_val),
        .multi_err(rp_err),
        .press_cnt(rp_cnt)
    );
`endif

    always #5 clk = ~clk;

    // Reference model: pipelined samples, streak-based debounce and a
    // "one command per 1111 -> pressed transition" front end.
    logic [3:0]  m_k1, m_ks, m_db, m_prev, m_op;
    logic [1:0]  m_m1, m_ms;
    logic [15:0] m_v1, m_vs, m_val;
    logic        m_pend, m_err;
    logic [7:0]  m_cnt;
    int          m_streak;

    function automatic void model_reset();
        m_k1 = 4'hF; m_ks = 4'hF; m_db = 4'hF; m_prev = 4'hF;
        m_m1 = '0; m_ms = '0; m_v1 = '0; m_vs = '0;
        m_pend = 1'b0; m_op = '0; m_val = '0; m_err = 1'b0; m_cnt = '0;
        m_streak = 0;
    endfunction

    task automatic model_step();
        logic [3:0]  ks   = m_ks;
        logic [3:0]  db   = m_db;
        logic [3:0]  prev = m_prev;
        logic [1:0]  ms   = m_ms;
        logic [15:0] vs   = m_vs;
        logic        pend = m_pend;
        int zeros;
        int idx;
        m_ks = m_k1; m_k1 = key_raw;
        m_ms = m_m1; m_m1 = mode_raw;
        m_vs = m_v1; m_v1 = val_raw;
        if (ks == db) m_streak = 0;
        else begin
            m_streak++;
            if (m_streak == DEB) begin
                m_db = ks;
                m_streak = 0;
            end
        end
        m_prev = db;
        m_err = 1'b0;
        if (pend && cmd_ready) begin
            m_pend = 1'b0;
            m_cnt  = m_cnt + 8'd1;
        end
        if (!pend && prev == 4'hF && db != 4'hF) begin
            zeros = 0;
            idx = 0;
            for (int b = 0; b < 4; b++) if (!db[b]) begin zeros++; idx = b; end
            if (zeros == 1) begin
                m_pend = 1'b1;
                m_op   = {ms, 2'(idx)};
                m_val  = vs;
            end else m_err = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        if (cmd_valid) n_valid++;
        if (multi_err) n_merr++;
        check("cycle", {2'b00, cmd_valid, cmd_op, cmd_val, multi_err, press_cnt},
                       {2'b00, m_pend, m_op, m_val, m_err, m_cnt});
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (!cmd_valid && lat < budget) begin
            step();
            lat++;
        end
        if (!cmd_valid) check("valid_timeout", 32'(cmd_valid), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [1:0]  mode;
        logic [15:0] val;
        logic        multi;
        logic [3:0]  op;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, b0, m0, got_v, got_e;
        logic [3:0]  got_op;
        logic [15:0] got_val;
        logic [3:0]  k;

        tbl[0] = '{4'b1110, 2'b00, 16'h0001, 1'b0, 4'b0000};
        tbl[1] = '{4'b1101, 2'b11, 16'hFFFF, 1'b0, 4'b1101};
        tbl[2] = '{4'b1011, 2'b10, 16'h8000, 1'b0, 4'b1010};
        tbl[3] = '{4'b0111, 2'b01, 16'h00A5, 1'b0, 4'b0111};
        tbl[4] = '{4'b0110, 2'b11, 16'h1111, 1'b1, 4'b0000};
        tbl[5] = '{4'b0000, 2'b10, 16'h2222, 1'b1, 4'b0000};

        model_reset();
        steps(3);
        rst = 1'b1;
        steps(2);

        // Reset mid-command and reset with a key held down.
        key_raw = 4'b1110; cmd_ready = 1'b0;
        wait_valid(20, lat);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_outputs", {cmd_valid, cmd_op, cmd_val, multi_err, press_cnt}, 32'd0);
        steps(3);
        key_raw = 4'hF;
        step();
        rst = 1'b1;
        b0 = n_valid;
        steps(15);
        check("no_cmd_after_rst", n_valid - b0, 0);

        // Clean press: latency and single-cycle valid.
        mode_raw = 2'b01; val_raw = 16'h1234; cmd_ready = 1'b1; key_raw = 4'b1011;
        wait_valid(20, lat);
        check("latency", lat, DEB + 3);
        check("clean_op", cmd_op, 4'b0110);
        check("clean_val", cmd_val, 16'h1234);
        step();
        check("clean_one_cycle", cmd_valid, 1'b0);
        check("clean_cnt", press_cnt, 8'd1);
        key_raw = 4'hF;
        steps(12);

        // Bounce.
        mode_raw = 2'b10;
        b0 = n_valid;
        for (int i = 0; i < 10; i++) begin
            key_raw = i[0] ? 4'hF : 4'hE;
            steps(2);
        end
        check("bounce_quiet", n_valid - b0, 0);
        key_raw = 4'hE;
        wait_valid(20, lat);
        check("bounce_op", cmd_op, 4'b1000);
        steps(10);
        check("bounce_once", n_valid - b0, 1);
        key_raw = 4'hF;
        steps(12);

        // Backpressure with val change and release during EMIT.
        mode_raw = 2'b01; val_raw = 16'h1234; cmd_ready = 1'b0; key_raw = 4'b1101;
        wait_valid(20, lat);
        val_raw = 16'hBEEF; key_raw = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", {cmd_valid, cmd_val}, {1'b1, 16'h1234});
        end
        cmd_ready = 1'b1;
        step();
        check("bp_drop", cmd_valid, 1'b0);
        steps(8);

        // Multi-key rejection, then a key3 press.
        check("multi_cnt_before", press_cnt, 8'd3);
        m0 = n_merr; b0 = n_valid;
        key_raw = 4'b1100;
        steps(14);
        check("multi_pulse", n_merr - m0, 1);
        check("multi_no_cmd", n_valid - b0, 0);
        check("multi_cnt_after", press_cnt, 8'd3);
        key_raw = 4'hF;
        steps(12);
        key_raw = 4'b0111;
        wait_valid(20, lat);
        check("multi_then_idx3", cmd_op[1:0], 2'd3);
        key_raw = 4'hF;
        steps(12);

        // Table-driven presses.
        for (int t = 0; t < 6; t++) begin
            mode_raw = tbl[t].mode; val_raw = tbl[t].val; key_raw = tbl[t].key; cmd_ready = 1'b1;
            got_v = 0; got_e = 0; got_op = '0; got_val = '0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (cmd_valid) begin got_v = 1; got_op = cmd_op; got_val = cmd_val; end
                if (multi_err) got_e = 1;
            end
            check("tbl_valid", got_v, 32'(!tbl[t].multi));
            check("tbl_err", got_e, 32'(tbl[t].multi));
            if (!tbl[t].multi) begin
                check("tbl_op", got_op, tbl[t].op);
                check("tbl_val", got_val, tbl[t].val);
            end
            key_raw = 4'hF;
            steps(12);
        end

        // Randomized presses against the model.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) < 7) k = ~(4'b0001 << $urandom_range(0, 3));
            else begin
                k = 4'($urandom);
                while ($countones(~k) < 2) k = 4'($urandom);
            end
            mode_raw = 2'($urandom);
            val_raw  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 4; j++) begin
                    key_raw = j[0] ? 4'hF : k;
                    steps($urandom_range(1, 3));
                end
            end
            key_raw = k;
            repeat ($urandom_range(3, 40)) begin
                cmd_ready = 1'($urandom);
                if ($urandom_range(0, 7) == 0) val_raw = 16'($urandom);
                step();
            end
            key_raw = 4'hF;
            repeat ($urandom_range(3, 25)) begin
                cmd_ready = 1'($urandom);
                step();
            end
        end
        cmd_ready = 1'b1;
        steps(20);

        // Counter wrap over 256 accepted presses.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int p = 0; p < 256; p++) begin
            key_raw = 4'b1110;
            steps(9);
            key_raw = 4'hF;
            steps(8);
            if (p == 254) check("cnt_255", press_cnt, 8'd255);
        end
        check("cnt_wrap", press_cnt, 8'd0);

`ifdef RPNKEY_AUTOREPEAT_EN
        // Auto-repeat on the REPEAT_CYCLES=32 instance.
        begin
            int first, nrep, gap;
            rst = 1'b0;
            step();
            rst = 1'b1;
            step();
            cmd_ready = 1'b1;
            key_raw = 4'b1101;
            first = 0;
            while (!rp_valid && first < 20) begin
                step();
                first++;
            end
            check("rep_first_cmd", rp_valid, 1'b1);
            nrep = 0; gap = 0;
            for (int i = 1; i <= 100; i++) begin
                step();
                if (rp_valid) begin
                    nrep++;
                    if (nrep == 1) gap = i;
                end
            end
            check("rep_count", nrep, 3);
            check("rep_gap", gap, 32);
            key_raw = 4'hF;
            steps(12);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
